// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART receiver and transmitter.
//   - uart_state_e : the four frame-level states (idle, start, data, stop)
//   - OVERSAMPLE   : s_tick pulses per bit period
//   - MID_TICK     : tick index at the centre of the start bit
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchronizer for the asynchronous serial line. Both flops reset
//   to 1 so that an idle (high) line is seen during and after reset, and no
//   false start edge is produced when reset is released.
//
//   Ports
//     clk   : in  - system clock, rising edge
//     reset : in  - synchronous, active-low
//     rx    : in  - raw asynchronous serial line
//     rx_s  : out - synchronized line, lags rx by 2 clk
// ---------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = rx;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q;

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   16x-oversampling UART receiver with a holding register and status flags.
//   The start bit is confirmed at its centre (tick MID_TICK); each data bit is
//   then sampled one full bit period (OVERSAMPLE ticks) later, LSB first. The
//   stop bit is sampled SB_TICK ticks after the last data bit. Frames with a
//   low stop bit are reported via frame_err and discarded.
//
//   Parameters
//     DBIT    : data bits per frame (2..8)
//     SB_TICK : stop-bit length in s_tick periods (16, 24 or 32)
//
//   Ports
//     clk          : in  - system clock, rising edge
//     reset        : in  - synchronous, active-low
//     s_tick       : in  - one-clk enable at 16x baud
//     rx           : in  - asynchronous serial line, idle high
//     rd_uart      : in  - consumer acknowledge, clears rx_ready/overrun
//     dout         : out - last good frame
//     rx_ready     : out - dout holds an unread byte
//     rx_done_tick : out - one-clk pulse per completed frame (good or bad)
//     frame_err    : out - last completed frame had a low stop bit
//     overrun      : out - sticky: good frame landed on an unread byte
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  input  logic            rd_uart,
  output logic [DBIT-1:0] dout,
  output logic            rx_ready,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            overrun
);

  localparam logic [4:0] MID_LAST  = 5'(MID_TICK);
  localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s)
  );

  uart_state_e     state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            rx_ready_q, rx_ready_d;
  logic            done_q, done_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    b_d         = b_q;
    dout_d      = dout_q;
    done_d      = 1'b0;
    frame_err_d = frame_err_q;
    // A read clears both flags; a good completion below may re-set rx_ready.
    rx_ready_d  = rx_ready_q & ~rd_uart;
    overrun_d   = overrun_q & ~rd_uart;

    unique case (state_q)
      ST_IDLE: begin
        // Start edge is taken immediately, not on a tick, so the first
        // clk of idle after a stop bit can already begin the next frame.
        if (!rx_s) begin
          s_d     = '0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (s_q == MID_LAST) begin
            if (!rx_s) begin
              s_d     = '0;
              n_d     = '0;
              state_d = ST_DATA;
            end else begin
              // Line back high at mid start bit: treat as a glitch.
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (s_q == STOP_LAST) begin
            state_d     = ST_IDLE;
            done_d      = 1'b1;
            frame_err_d = ~rx_s;
            if (rx_s) begin
              dout_d     = b_q;
              rx_ready_d = 1'b1;
              // Overwriting an unread byte is an overrun unless the consumer
              // is reading it in this very clk.
              overrun_d  = (overrun_q | rx_ready_q) & ~rd_uart;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      n_q         <= '0;
      b_q         <= '0;
      dout_q      <= '0;
      rx_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      b_q         <= b_d;
      dout_q      <= dout_d;
      rx_ready_q  <= rx_ready_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign dout         = dout_q;
  assign rx_ready     = rx_ready_q;
  assign rx_done_tick = done_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx: expected completions are queued when a frame
//   is sent and compared against the outputs when rx_done_tick pulses.
// ---------------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = 64;  // 16 ticks x 4 clk per tick

  typedef struct packed {
    logic [7:0] dout;
    logic       fe;
    logic       rdy;
    logic       ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rd_uart = 1'b0;
  logic [7:0] dout;
  logic       rx_ready;
  logic       rx_done_tick;
  logic       frame_err;
  logic       overrun;

  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  logic done_prev = 1'b0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .rd_uart      (rd_uart),
    .dout         (dout),
    .rx_ready     (rx_ready),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // s_tick: one clk high out of every four.
  initial begin : tick_gen
    int unsigned ph;
    ph = 0;
    forever begin
      @(negedge clk);
      s_tick = (ph == 0);
      ph = (ph + 1) % 4;
    end
  end

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      exp_t e;
      done_cnt++;
      check("done_single_clk", {31'd0, done_prev}, 32'd0);
      check("done_expected", {31'd0, (sb_q.size() != 0)}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_dout", {24'd0, dout}, {24'd0, e.dout});
        check("sb_frame_err", {31'd0, frame_err}, {31'd0, e.fe});
        check("sb_rx_ready", {31'd0, rx_ready}, {31'd0, e.rdy});
        check("sb_overrun", {31'd0, overrun}, {31'd0, e.ovr});
      end
    end
    done_prev = rx_done_tick;
  end

  // rst_bit >= 0 pulses reset low for 1 clk in the middle of that data bit.
  task automatic send_frame(input logic [7:0] data, input bit good_stop, input int rst_bit);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      if (i == rst_bit) begin
        repeat (32) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (BIT_CLKS - 33) @(negedge clk);
      end else begin
        repeat (BIT_CLKS) @(negedge clk);
      end
    end
    if (good_stop) begin
      rx = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
    end else begin
      // Low long enough to be sampled, high again before the next mid-start.
      rx = 1'b0;
      repeat (48) @(negedge clk);
      rx = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic pulse_rd();
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask

  initial begin
    bit hit;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_done", {31'd0, rx_done_tick}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Good frame 0xA5
    sb_q.push_back('{dout: 8'hA5, fe: 1'b0, rdy: 1'b1, ovr: 1'b0});
    send_frame(8'hA5, 1'b1, -1);
    repeat (20) @(negedge clk);
    check("a5_done_cnt", done_cnt, 1);
    check("a5_consumed", sb_q.size(), 0);

    // Start glitch of 3 tick periods
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_done_cnt", done_cnt, 1);
    check("glitch_dout", {24'd0, dout}, 32'h0000_00A5);
    check("glitch_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("glitch_frame_err", {31'd0, frame_err}, 32'd0);
    check("glitch_state_idle", {30'd0, dut.state_q}, {30'd0, ST_IDLE});

    pulse_rd();
    check("rd_clears_ready", {31'd0, rx_ready}, 32'd0);

    // Framing error on 0x3C: dout kept at A5, rx_ready stays 0
    sb_q.push_back('{dout: 8'hA5, fe: 1'b1, rdy: 1'b0, ovr: 1'b0});
    send_frame(8'h3C, 1'b0, -1);
    repeat (100) @(negedge clk);
    check("fe_done_cnt", done_cnt, 2);
    check("fe_holds", {31'd0, frame_err}, 32'd1);

    // Back-to-back 0x11, 0x22 without reads -> overrun
    sb_q.push_back('{dout: 8'h11, fe: 1'b0, rdy: 1'b1, ovr: 1'b0});
    sb_q.push_back('{dout: 8'h22, fe: 1'b0, rdy: 1'b1, ovr: 1'b1});
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    repeat (20) @(negedge clk);
    check("ovr_done_cnt", done_cnt, 4);
    pulse_rd();
    check("ovr_rd_ready", {31'd0, rx_ready}, 32'd0);
    check("ovr_rd_overrun", {31'd0, overrun}, 32'd0);
    check("ovr_dout_kept", {24'd0, dout}, 32'h0000_0022);

    // 0x77 left unread, then 0x55 completes with rd_uart in the same clk
    sb_q.push_back('{dout: 8'h77, fe: 1'b0, rdy: 1'b1, ovr: 1'b0});
    send_frame(8'h77, 1'b1, -1);
    sb_q.push_back('{dout: 8'h55, fe: 1'b0, rdy: 1'b1, ovr: 1'b0});
    hit = 1'b0;
    fork
      send_frame(8'h55, 1'b1, -1);
      begin
        for (int k = 0; k < 2000 && !hit; k++) begin
          @(negedge clk);
          #1;
          if (dut.state_q == ST_STOP && dut.s_q == 5'd15 && s_tick) begin
            rd_uart = 1'b1;
            @(negedge clk);
            rd_uart = 1'b0;
            hit = 1'b1;
          end
        end
      end
    join
    check("rd_same_clk_window", {31'd0, hit}, 32'd1);
    repeat (20) @(negedge clk);
    check("rd_same_clk_done_cnt", done_cnt, 6);
    check("rd_same_clk_dout", {24'd0, dout}, 32'h0000_0055);
    check("rd_same_clk_ready", {31'd0, rx_ready}, 32'd1);
    check("rd_same_clk_overrun", {31'd0, overrun}, 32'd0);
    pulse_rd();

    // Reset during data bit 4 of 0xF0, then 0x0F
    send_frame(8'hF0, 1'b1, 4);
    repeat (100) @(negedge clk);
    check("midrst_done_cnt", done_cnt, 6);
    check("midrst_dout", {24'd0, dout}, 32'd0);
    check("midrst_ready", {31'd0, rx_ready}, 32'd0);
    sb_q.push_back('{dout: 8'h0F, fe: 1'b0, rdy: 1'b1, ovr: 1'b0});
    send_frame(8'h0F, 1'b1, -1);
    repeat (20) @(negedge clk);
    check("resync_done_cnt", done_cnt, 7);
    check("resync_dout", {24'd0, dout}, 32'h0000_000F);
    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_rx
